// File: rtl/sm_cnt_upd_pkg.sv
// Shared types and helpers for the counter-update engine and its forwarding history.
package sm_cnt_upd_pkg;

  // The history entry is sized for the widest legal configuration. Modules zero-extend into it.
  localparam int unsigned MaxBitAddr = 32;
  localparam int unsigned MaxBitData = 64;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  typedef struct packed {
    logic                  vld;
    logic [MaxBitAddr-1:0] adr;
    logic [MaxBitData-1:0] data;
  } wr_hist_t;

  // Returns {sat, value}. old and dlt must already fit in 'width' bits.
  function automatic logic [MaxBitData:0] sat_add(input logic [MaxBitData-1:0] old,
                                                  input logic [MaxBitData-1:0] dlt,
                                                  input int unsigned           width);
    logic [MaxBitData:0] sum;
    logic [MaxBitData:0] lim;
    logic [MaxBitData:0] ones;
    sum  = {1'b0, old} + {1'b0, dlt};
    lim  = {{MaxBitData{1'b0}}, 1'b1} << width;
    ones = lim - {{MaxBitData{1'b0}}, 1'b1};
    if (sum >= lim) begin
      sat_add = {1'b1, ones[MaxBitData-1:0]};
    end else begin
      sat_add = {1'b0, sum[MaxBitData-1:0]};
    end
  endfunction

endpackage

// File: rtl/sm_cnt_upd_if.sv
// Update, lookup and status signals of the counter-update engine.
interface sm_cnt_upd_if #(
  parameter int unsigned BITADDR = 10,
  parameter int unsigned BITDATA = 45,
  parameter int unsigned BITDLT  = 16
) ();

  logic               upd_vld;
  logic               upd_rdy;
  logic [BITADDR-1:0] upd_adr;
  logic [BITDLT-1:0]  upd_dlt;
  logic               lkp_vld;
  logic               lkp_rdy;
  logic [BITADDR-1:0] lkp_adr;
  logic [BITDATA-1:0] lkp_dout;
  logic               lkp_dvld;
  logic               init_done;
  logic               sat_evt;

  modport master (
    output upd_vld, upd_adr, upd_dlt, lkp_vld, lkp_adr,
    input  upd_rdy, lkp_rdy, lkp_dout, lkp_dvld, init_done, sat_evt
  );

  modport slave (
    input  upd_vld, upd_adr, upd_dlt, lkp_vld, lkp_adr,
    output upd_rdy, lkp_rdy, lkp_dout, lkp_dvld, init_done, sat_evt
  );

endinterface

// File: rtl/sm_cnt_fwd.sv
// Write history covering the memory read latency; returns the newest write to a queried address.
module sm_cnt_fwd
  import sm_cnt_upd_pkg::*;
#(
  parameter int unsigned RdDly   = 1,
  parameter int unsigned BITADDR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld,
  input  logic [BITADDR-1:0]    push_adr,
  input  logic [MaxBitData-1:0] push_data,
  input  logic [BITADDR-1:0]    qry_adr,
  output logic                  hit,
  output logic [MaxBitData-1:0] hit_data
);

  wr_hist_t hist_q [RdDly];

  // Entry 0 is the write issued in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RdDly); i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      hist_q[0] <= '{vld: push_vld, adr: MaxBitAddr'(push_adr), data: push_data};
      for (int i = 1; i < int'(RdDly); i++) begin
        hist_q[i] <= hist_q[i-1];
      end
    end
  end

  // Scan oldest to newest so the newest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = int'(RdDly) - 1; i >= 0; i--) begin
      if (hist_q[i].vld && (hist_q[i].adr == MaxBitAddr'(qry_adr))) begin
        hit      = 1'b1;
        hit_data = hist_q[i].data;
      end
    end
  end

endmodule

// File: rtl/sm_cnt_upd.sv
// Counter-update engine: zero-fills the counter memory, then runs a forwarded read-add-write
// pipeline at one update per cycle alongside a pass-through lookup port.
module sm_cnt_upd
  import sm_cnt_upd_pkg::*;
#(
  parameter int unsigned NUMADDR = 1024,
  parameter int unsigned BITADDR = 10,
  parameter int unsigned BITDATA = 45,
  parameter int unsigned BITDLT  = 16,
  parameter int unsigned FLOPOUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  sm_cnt_upd_if.slave        bus,
  output logic               sm_mem_write,
  output logic [BITADDR-1:0] sm_mem_wr_adr  [0:0],
  output logic [BITDATA-1:0] sm_mem_din     [0:0],
  output logic [1:0]         sm_mem_read,
  output logic [BITADDR-1:0] sm_mem_rd_adr  [0:1],
  input  logic [BITDATA-1:0] sm_mem_rd_dout [0:1]
);

  localparam int unsigned RdDly = 1 + FLOPOUT;

  state_e             state_q, state_d;
  logic [BITADDR-1:0] fill_q, fill_d;
  logic [RdDly-1:0]   pv_q;
  logic [BITADDR-1:0] pa_q [RdDly];
  logic [BITDLT-1:0]  pd_q [RdDly];
  logic [RdDly-1:0]   lv_q;

  logic                  run;
  logic                  upd_acc;
  logic                  lkp_acc;
  logic                  ws_vld;
  logic [BITADDR-1:0]    ws_adr;
  logic                  fwd_hit;
  logic [MaxBitData-1:0] fwd_data;
  logic [MaxBitData-1:0] old_val;
  logic [MaxBitData:0]   add_res;

  assign run     = (state_q == StRun) && !rst;
  assign upd_acc = run && bus.upd_vld;
  assign lkp_acc = run && bus.lkp_vld;
  assign ws_vld  = run && pv_q[RdDly-1];
  assign ws_adr  = pa_q[RdDly-1];
  assign old_val = fwd_hit ? fwd_data : MaxBitData'(sm_mem_rd_dout[0]);
  assign add_res = sat_add(old_val, MaxBitData'(pd_q[RdDly-1]), BITDATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      fill_q  <= '0;
      pv_q    <= '0;
      lv_q    <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pv_q[0] <= upd_acc;
      lv_q[0] <= lkp_acc;
      for (int i = 1; i < int'(RdDly); i++) begin
        pv_q[i] <= pv_q[i-1];
        lv_q[i] <= lv_q[i-1];
      end
    end
  end

  // Payload flops need no reset; their valids gate every use.
  always_ff @(posedge clk) begin
    pa_q[0] <= bus.upd_adr;
    pd_q[0] <= bus.upd_dlt;
    for (int i = 1; i < int'(RdDly); i++) begin
      pa_q[i] <= pa_q[i-1];
      pd_q[i] <= pd_q[i-1];
    end
  end

  sm_cnt_fwd #(
    .RdDly  (RdDly),
    .BITADDR(BITADDR)
  ) u_fwd (
    .clk      (clk),
    .rst      (rst),
    .push_vld (ws_vld),
    .push_adr (ws_adr),
    .push_data(add_res[MaxBitData-1:0]),
    .qry_adr  (ws_adr),
    .hit      (fwd_hit),
    .hit_data (fwd_data)
  );

  always_comb begin
    state_d          = state_q;
    fill_d           = fill_q;
    sm_mem_write     = 1'b0;
    sm_mem_wr_adr[0] = '0;
    sm_mem_din[0]    = '0;
    sm_mem_read      = 2'b00;
    sm_mem_rd_adr[0] = bus.upd_adr;
    sm_mem_rd_adr[1] = bus.lkp_adr;
    bus.upd_rdy      = 1'b0;
    bus.lkp_rdy      = 1'b0;
    bus.lkp_dvld     = 1'b0;
    bus.lkp_dout     = sm_mem_rd_dout[1];
    bus.init_done    = 1'b0;
    bus.sat_evt      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StInit: begin
          sm_mem_write     = 1'b1;
          sm_mem_wr_adr[0] = fill_q;
          fill_d           = fill_q + 1'b1;
          if (fill_q == BITADDR'(NUMADDR - 1)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          bus.upd_rdy      = 1'b1;
          bus.lkp_rdy      = 1'b1;
          bus.init_done    = 1'b1;
          bus.lkp_dvld     = lv_q[RdDly-1];
          sm_mem_read      = {lkp_acc, upd_acc};
          sm_mem_write     = ws_vld;
          sm_mem_wr_adr[0] = ws_adr;
          sm_mem_din[0]    = add_res[BITDATA-1:0];
          bus.sat_evt      = ws_vld && add_res[MaxBitData];
        end
        default: state_d = StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_cnt_upd.sv
// Bench for sm_cnt_upd: two instances (FLOPOUT 0 and 1) share stimulus, each with its own memory.
module tb_sm_cnt_upd;
  import sm_cnt_upd_pkg::*;

  localparam int NA = 16;
  localparam int BA = 4;
  localparam int BD = 8;
  localparam int BL = 8;
  localparam int NC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          upd_vld;
  logic [BA-1:0] upd_adr;
  logic [BL-1:0] upd_dlt;
  logic          lkp_vld;
  logic [BA-1:0] lkp_adr;

  logic          upd_rdy_w [2];
  logic          lkp_rdy_w [2];
  logic          dvld_w    [2];
  logic [BD-1:0] dout_w    [2];
  logic          idone_w   [2];
  logic          sat_w     [2];
  logic          wr_w      [2];
  logic [BA-1:0] wadr_w    [2];
  logic [BD-1:0] din_w     [2];
  logic [1:0]    rd_w      [2];
  logic [BA-1:0] radr0_w   [2];
  logic [BA-1:0] radr1_w   [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sm_cnt_upd_if #(.BITADDR(BA), .BITDATA(BD), .BITDLT(BL)) bus ();
    logic          wr;
    logic [BA-1:0] wadr  [0:0];
    logic [BD-1:0] din   [0:0];
    logic [1:0]    rd;
    logic [BA-1:0] radr  [0:1];
    logic [BD-1:0] rdout [0:1];
    logic [BD-1:0] mem   [NA];
    logic [BD-1:0] rq1   [0:1];
    logic [BD-1:0] rq2   [0:1];

    assign bus.upd_vld = upd_vld;
    assign bus.upd_adr = upd_adr;
    assign bus.upd_dlt = upd_dlt;
    assign bus.lkp_vld = lkp_vld;
    assign bus.lkp_adr = lkp_adr;

    sm_cnt_upd #(
      .NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .BITDLT(BL), .FLOPOUT(g)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .sm_mem_write  (wr),
      .sm_mem_wr_adr (wadr),
      .sm_mem_din    (din),
      .sm_mem_read   (rd),
      .sm_mem_rd_adr (radr),
      .sm_mem_rd_dout(rdout)
    );

    // Memory: read-before-write in the same cycle, optional output flop.
    always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
        if (rd[p]) rq1[p] <= mem[radr[p]];
        rq2[p] <= rq1[p];
      end
      if (wr) mem[wadr[0]] <= din[0];
    end
    assign rdout[0] = (g == 0) ? rq1[0] : rq2[0];
    assign rdout[1] = (g == 0) ? rq1[1] : rq2[1];

    assign upd_rdy_w[g] = bus.upd_rdy;
    assign lkp_rdy_w[g] = bus.lkp_rdy;
    assign dvld_w[g]    = bus.lkp_dvld;
    assign dout_w[g]    = bus.lkp_dout;
    assign idone_w[g]   = bus.init_done;
    assign sat_w[g]     = bus.sat_evt;
    assign wr_w[g]      = wr;
    assign wadr_w[g]    = wadr[0];
    assign din_w[g]     = din[0];
    assign rd_w[g]      = rd;
    assign radr0_w[g]   = radr[0];
    assign radr1_w[g]   = radr[1];
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, inst, cyc, act, exp);
    end
  endtask

  // Reference model: counters updated in acceptance order with saturation; memory-visible state
  // advances at write time, and a lookup sees the state as of the cycle it is accepted.
  logic          acc_u [NC];
  logic          acc_l [NC];
  logic [BA-1:0] uadr  [NC];
  logic [BL-1:0] udlt  [NC];
  logic [BD-1:0] lexp  [2][NC];
  logic [BD-1:0] cnt   [2][NA];
  int            fill  [2] = '{0, 0};
  int            last_rst = -1;

  logic [BD-1:0] wlog [2][256];
  logic          slog [2][256];
  int            wn   [2] = '{0, 0};
  logic [BD-1:0] llog [2][256];
  int            ln   [2] = '{0, 0};

  always @(negedge clk) begin
    int t;
    int d;
    int s;
    logic run_m;
    cyc++;
    t     = cyc;
    run_m = !rst && (fill[0] >= NA);
    acc_u[t] = run_m && upd_vld;
    acc_l[t] = run_m && lkp_vld;
    uadr[t]  = upd_adr;
    udlt[t]  = upd_dlt;
    for (int i = 0; i < 2; i++) begin
      d = 1 + i;
      if (rst) begin
        chk("rst_upd_rdy", i, upd_rdy_w[i], 0);
        chk("rst_lkp_rdy", i, lkp_rdy_w[i], 0);
        chk("rst_dvld", i, dvld_w[i], 0);
        chk("rst_init_done", i, idone_w[i], 0);
        chk("rst_sat", i, sat_w[i], 0);
        chk("rst_read", i, rd_w[i], 0);
        chk("rst_write", i, wr_w[i], 0);
        fill[i] = 0;
        for (int a = 0; a < NA; a++) cnt[i][a] = '0;
      end else if (fill[i] < NA) begin
        chk("init_write", i, wr_w[i], 1);
        chk("init_wadr", i, wadr_w[i], fill[i]);
        chk("init_din", i, din_w[i], 0);
        chk("init_done_low", i, idone_w[i], 0);
        chk("init_upd_rdy", i, upd_rdy_w[i], 0);
        chk("init_read", i, rd_w[i], 0);
        chk("init_dvld", i, dvld_w[i], 0);
        chk("init_sat", i, sat_w[i], 0);
        fill[i]++;
      end else begin
        chk("run_init_done", i, idone_w[i], 1);
        chk("run_rdy", i, {upd_rdy_w[i], lkp_rdy_w[i]}, 2'b11);
        chk("run_read", i, rd_w[i], {lkp_vld, upd_vld});
        if (upd_vld) chk("rd_adr0", i, radr0_w[i], upd_adr);
        if (lkp_vld) chk("rd_adr1", i, radr1_w[i], lkp_adr);
        lexp[i][t] = cnt[i][lkp_adr];
        if (t > d && acc_u[t-d] && last_rst < t - d) begin
          s = int'(cnt[i][uadr[t-d]]) + int'(udlt[t-d]);
          chk("wr_en", i, wr_w[i], 1);
          chk("wr_adr", i, wadr_w[i], uadr[t-d]);
          chk("wr_data", i, din_w[i], (s > 255) ? 255 : s);
          chk("sat_evt", i, sat_w[i], s > 255);
          cnt[i][uadr[t-d]] = (s > 255) ? 8'hFF : s[BD-1:0];
          wlog[i][wn[i] & 255] = din_w[i];
          slog[i][wn[i] & 255] = sat_w[i];
          wn[i]++;
        end else begin
          chk("wr_idle", i, wr_w[i], 0);
          chk("sat_idle", i, sat_w[i], 0);
        end
        if (t > d && acc_l[t-d] && last_rst < t - d) begin
          chk("lkp_dvld", i, dvld_w[i], 1);
          chk("lkp_dout", i, dout_w[i], lexp[i][t-d]);
          llog[i][ln[i] & 255] = dout_w[i];
          ln[i]++;
        end else begin
          chk("lkp_dvld_idle", i, dvld_w[i], 0);
        end
      end
    end
    if (rst) last_rst = t;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    upd_vld = 1'b0;
    lkp_vld = 1'b0;
    repeat (n) step();
  endtask

  task automatic lookup_all();
    for (int a = 0; a < NA; a++) begin
      lkp_vld = 1'b1;
      lkp_adr = BA'(a);
      step();
    end
    quiet(4);
  endtask

  task automatic lkp_one(input logic [BA-1:0] a, input logic [BD-1:0] exp);
    int n0 [2];
    n0 = ln;
    lkp_vld = 1'b1;
    lkp_adr = a;
    step();
    quiet(4);
    for (int i = 0; i < 2; i++) begin
      chk("lkp_one_count", i, ln[i] - n0[i], 1);
      chk("lkp_one_value", i, llog[i][n0[i] & 255], exp);
    end
  endtask

  task automatic refill();
    quiet(NA);
    for (int i = 0; i < 2; i++) chk("init_done_rise", i, idone_w[i], 1);
  endtask

  typedef struct {
    logic [BA-1:0] adr;
    logic [BL-1:0] dlt;
    logic [BD-1:0] exp_w;
    logic          exp_sat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int w0 [2];
    tbl[0] = '{adr: 4'd5, dlt: 8'd3,   exp_w: 8'd3,   exp_sat: 1'b0};
    tbl[1] = '{adr: 4'd7, dlt: 8'd1,   exp_w: 8'd1,   exp_sat: 1'b0};
    tbl[2] = '{adr: 4'd7, dlt: 8'd2,   exp_w: 8'd3,   exp_sat: 1'b0};
    tbl[3] = '{adr: 4'd7, dlt: 8'd3,   exp_w: 8'd6,   exp_sat: 1'b0};
    tbl[4] = '{adr: 4'd7, dlt: 8'd4,   exp_w: 8'd10,  exp_sat: 1'b0};
    tbl[5] = '{adr: 4'd2, dlt: 8'd250, exp_w: 8'd250, exp_sat: 1'b0};
    tbl[6] = '{adr: 4'd2, dlt: 8'd10,  exp_w: 8'hFF,  exp_sat: 1'b1};
    tbl[7] = '{adr: 4'd2, dlt: 8'd1,   exp_w: 8'hFF,  exp_sat: 1'b1};
    tbl[8] = '{adr: 4'd2, dlt: 8'd0,   exp_w: 8'hFF,  exp_sat: 1'b0};
    tbl[9] = '{adr: 4'd9, dlt: 8'd0,   exp_w: 8'd0,   exp_sat: 1'b0};

    rst = 1'b1;
    upd_vld = 1'b0; upd_adr = '0; upd_dlt = '0;
    lkp_vld = 1'b0; lkp_adr = '0;
    repeat (3) step();
    rst = 1'b0;
    refill();
    step();
    lookup_all();

    // Back-to-back updates, same-address hazards and saturation.
    w0 = wn;
    for (int k = 0; k < 10; k++) begin
      upd_vld = 1'b1;
      upd_adr = tbl[k].adr;
      upd_dlt = tbl[k].dlt;
      step();
    end
    quiet(4);
    for (int i = 0; i < 2; i++) begin
      chk("tbl_write_count", i, wn[i] - w0[i], 10);
      for (int k = 0; k < 10; k++) begin
        chk("tbl_wdata", i, wlog[i][(w0[i] + k) & 255], tbl[k].exp_w);
        chk("tbl_sat", i, slog[i][(w0[i] + k) & 255], tbl[k].exp_sat);
      end
    end
    lkp_one(4'd5, 8'd3);
    lkp_one(4'd7, 8'd10);
    lkp_one(4'd2, 8'hFF);

    // Reset with two updates in flight.
    upd_vld = 1'b1; upd_adr = 4'd3; upd_dlt = 8'd5;
    step();
    upd_adr = 4'd4; upd_dlt = 8'd6;
    step();
    upd_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    refill();
    step();
    lookup_all();
    lkp_one(4'd3, 8'd0);
    lkp_one(4'd4, 8'd0);
    lkp_one(4'd7, 8'd0);

    // Alternating addresses with a lookup every cycle.
    for (int k = 0; k < 100; k++) begin
      upd_vld = 1'b1;
      upd_adr = (k % 2 == 0) ? 4'd1 : 4'd2;
      upd_dlt = 8'd1;
      lkp_vld = 1'b1;
      lkp_adr = (k % 2 == 0) ? 4'd2 : 4'd1;
      step();
    end
    quiet(4);
    lkp_one(4'd1, 8'd50);
    lkp_one(4'd2, 8'd50);

    // Random traffic, biased toward a few addresses to stress forwarding.
    for (int k = 0; k < 400; k++) begin
      upd_vld = ($urandom_range(0, 3) != 0);
      upd_adr = ($urandom_range(0, 3) == 0) ? BA'($urandom_range(0, NA - 1))
                                            : BA'($urandom_range(8, 10));
      upd_dlt = ($urandom_range(0, 7) == 0) ? BL'($urandom_range(0, 255))
                                            : BL'($urandom_range(0, 6));
      lkp_vld = ($urandom_range(0, 1) != 0);
      lkp_adr = BA'($urandom_range(0, NA - 1));
      step();
    end
    quiet(4);
    lookup_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sm_cnt_upd.md
Name: sm_cnt_upd

Overview:
Counter-update engine that sits directly upstream of mem_sm_mem (2 read ports, 1 write port) and owns all of its ports. It accepts increment requests (address, delta) and runs a pipelined read-add-write loop against the memory. Same-address hazards are resolved by forwarding, so back-to-back updates to one counter are exact. After reset it zero-fills the memory before accepting traffic, and it passes a lookup port through to memory read port 1.

Parameters:
NUMADDR, 1024, number of counters (memory depth)
BITADDR, 10, address width; must satisfy 2^BITADDR >= NUMADDR
BITDATA, 45, counter width (memory data width)
BITDLT, 16, increment width; must be <= BITDATA
FLOPOUT, 0, memory output flop setting; must match the mem_sm_mem instance

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
upd_vld  in  1  update request valid
upd_rdy  out  1  update request accepted when upd_vld && upd_rdy
upd_adr  in  BITADDR  counter address
upd_dlt  in  BITDLT  increment, zero-extended
lkp_vld  in  1  lookup request
lkp_rdy  out  1  lookup accepted
lkp_adr  in  BITADDR  lookup address
lkp_dout  out  BITDATA  lookup data, valid RD_DLY cycles after acceptance
lkp_dvld  out  1  lkp_dout valid strobe
init_done  out  1  high once zero-fill is complete
sat_evt  out  1  one-cycle pulse when a write saturates
sm_mem_write  out  1  memory write enable (write port 0)
sm_mem_wr_adr  out  BITADDR x1  memory write address (unpacked array [0:0])
sm_mem_din  out  BITDATA x1  memory write data (unpacked array [0:0])
sm_mem_read  out  2  memory read enables; bit0 = update path, bit1 = lookup path
sm_mem_rd_adr  out  BITADDR x2  memory read addresses (unpacked array [0:1])
sm_mem_rd_dout  in  BITDATA x2  memory read data (unpacked array [0:1])

Behaviour:
- Memory timing contract: RD_DLY = 1 + FLOPOUT. Read data is valid RD_DLY cycles after the read-enable cycle.
- A write issued in cycle t is visible to reads issued at t+1 or later. A read in the same cycle as a write to the same address returns the old value.
- FSM states: INIT, RUN.
- Reset: rst=1 forces INIT, sets the fill counter to 0, and clears all pipeline valids and the write history.
  - While rst=1 or in INIT, these outputs are 0: upd_rdy, lkp_rdy, lkp_dvld, init_done, sat_evt, sm_mem_read.
  - A reset mid-operation discards in-flight updates and restarts the fill.
- INIT:
  - Each cycle: sm_mem_write=1, wr_adr=fill counter, din=0, then fill counter +1.
  - After writing address NUMADDR-1, move to RUN on the next cycle.
  - Fill takes exactly NUMADDR cycles.
- RUN:
  - upd_rdy=1 and lkp_rdy=1 every cycle. There is no backpressure; the pipeline is fully pipelined at 1 update/cycle.
  - On update accept at cycle t: sm_mem_read[0]=1 and rd_adr[0]=upd_adr in cycle t. Address and delta travel down an RD_DLY-deep valid/addr/delta pipeline.
  - At cycle t+RD_DLY (write stage), old = sm_mem_rd_dout[0], overridden by the newest matching entry of the write history.
    - The write history holds the last RD_DLY writes issued in cycles t .. t+RD_DLY-1 (valid, addr, data).
    - Newest match wins.
  - sum = old + zero-extended dlt, computed in BITDATA+1 bits.
    - If the carry is set: write all-ones and pulse sat_evt in that cycle.
    - Otherwise write sum.
  - The write occurs in the write-stage cycle: sm_mem_write=1 with the final address and data. The same value is pushed into the write history.
  - Lookup: sm_mem_read[1]=lkp_vld, rd_adr[1]=lkp_adr. lkp_dvld = lkp accept delayed RD_DLY; lkp_dout = sm_mem_rd_dout[1].
    - Lookups are not forwarded: they see memory contents per the timing contract.
- sm_mem_write=0 in RUN unless the write stage is valid.
- init_done=1 throughout RUN.
- Updates at unrelated addresses never interact.
- Delta 0 still performs a read and a write.

Decomposition:
- Package sm_cnt_upd_pkg holds:
  - state enum (INIT, RUN)
  - wr_hist_t struct (vld, adr, data), parameterised through the module
  - function sat_add(old, dlt) returning {sat, value}
- One natural sub-module: sm_cnt_fwd, the RD_DLY-deep write-history shift register with newest-match lookup.
- mem_sm_mem itself is instantiated by the parent, not inside this block.

Test Plan:
- Init: NUMADDR=16, release reset → sm_mem_write high for exactly 16 cycles with addresses 0..15 and din=0 → init_done rises the next cycle; lookups of all 16 addresses return 0.
- Single update: adr=5, dlt=3, then lookup adr=5 after RD_DLY+1 cycles → lkp_dout=3, sat_evt=0.
- Back-to-back hazard: 4 consecutive updates to adr=7 with dlt=1,2,3,4 at FLOPOUT=0 and at FLOPOUT=1 → final lookup = 10; memory write sequence 1,3,6,10.
- Saturation: BITDATA=8; update adr=2 dlt=250, then dlt=10 → second write = 0xFF with one sat_evt pulse; a further dlt=1 writes 0xFF and pulses again.
- Interleave: alternating updates to adr=1 and adr=2 (dlt=1) for 100 cycles, lookups every cycle → final values 50 and 50; no cross-address forwarding.
- Reset mid-run: assert rst for 1 cycle while 2 updates are in flight → no writes from the discarded updates after reset; full re-fill; all counters read 0.
